wb_memsys: RTL



---
 rtl/wb_memsys_if.sv | 33 +++
 rtl/wb_memsys.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_memsys_if.sv
// wb_memsys_if
//   Wishbone classic bus bundle between a master and wb_memsys.
//   master modport: drives cyc/stb/we/adr/sel/dat_i, observes dat_o/ack/err.
//   slave  modport: the mirror view, used by wb_memsys.
//   Signals:
//     wb_cyc_i, wb_stb_i, wb_we_i   1   cycle, strobe, write enable
//     wb_adr_i                      32  byte address
//     wb_sel_i                      4   byte lane enables
//     wb_dat_i                      32  write data
//     wb_dat_o                      32  read data
//     wb_ack_o                      1   successful termination
//     wb_err_o                      1   error termination
interface wb_memsys_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_memsys.sv
// wb_memsys
//   Multi-region Wishbone classic memory with fixed access latency, per-region
//   read-only protection and a backdoor preload port.
//   Ports:
//     clk        in   clock, all state on rising edge
//     rst        in   synchronous reset, active-low
//     bus        slave modport of wb_memsys_if (Wishbone classic)
//     ld_en      in   backdoor write strobe
//     ld_region  in   backdoor target region
//     ld_addr    in   backdoor word index within region
//     ld_data    in   backdoor write data (all lanes)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; accepts cyc&stb and latches the request
//   WAIT  | latency countdown; cyc or stb low aborts without effect
//   DONE  | one-cycle termination: ack or err, write commits at its edge
module wb_memsys #(
    parameter int                    REGIONS = 2,
    parameter logic [32*REGIONS-1:0] BASES   = {32'h80000000, 32'h00400000},
    parameter logic [8*REGIONS-1:0]  BITS    = {8'd17, 8'd16},
    parameter logic [REGIONS-1:0]    RO      = 2'b01,
    parameter int                    LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_memsys_if.slave  bus,
    input  logic        ld_en,
    input  logic [1:0]  ld_region,
    input  logic [17:0] ld_addr,
    input  logic [31:0] ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Widest word index over all regions; smaller regions use its low bits.
    function automatic int max_aw();
        int m;
        m = 1;
        for (int i = 0; i < REGIONS; i++) begin
            if (int'(BITS[8*i +: 8]) - 2 > m) m = int'(BITS[8*i +: 8]) - 2;
        end
        return m;
    endfunction

    localparam int MAXAW = max_aw();

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [MAXAW-1:0]   widx_q;
    logic [31:0]        dat_q;
    logic [3:0]         sel_q;
    logic               we_q;
    logic               err_q;
    logic [1:0]         region_q;

    logic               req;
    logic               hit;
    logic               hit_ro;
    logic [1:0]         hit_region;
    logic               done_ok;
    logic               bus_wr;
    logic [31:0]        rd_sel;
    logic [31:0]        rd_word [REGIONS];

    assign req = bus.wb_cyc_i & bus.wb_stb_i;

    // Iterating from the top index down lets the lowest hitting region win.
    // 33-bit compare keeps a region ending at 2**32 from wrapping.
    always_comb begin
        hit        = 1'b0;
        hit_region = '0;
        hit_ro     = 1'b0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (({1'b0, bus.wb_adr_i} >= {1'b0, BASES[32*i +: 32]}) &&
                ({1'b0, bus.wb_adr_i} <  ({1'b0, BASES[32*i +: 32]} +
                                          (33'd1 << BITS[8*i +: 8])))) begin
                hit        = 1'b1;
                hit_region = 2'(i);
                hit_ro     = RO[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            widx_q   <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            region_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                widx_q   <= bus.wb_adr_i[MAXAW+1:2];
                dat_q    <= bus.wb_dat_i;
                sel_q    <= bus.wb_sel_i;
                we_q     <= bus.wb_we_i;
                err_q    <= ~hit | (bus.wb_we_i & hit_ro);
                region_q <= hit_region;
            end
        end
    end

    // Terminal count is 1 rather than 0 so DONE lands exactly LATENCY cycles
    // after acceptance; the counter reads 0 once DONE is entered.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt <= 4'd1) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign done_ok = (state == DONE) && !err_q;
    // Reset at the DONE edge discards the write as well.
    assign bus_wr  = done_ok && we_q && rst;

    for (genvar g = 0; g < REGIONS; g++) begin : g_region
        localparam int AW    = int'(BITS[8*g +: 8]) - 2;
        localparam int WORDS = 1 << AW;

        logic [31:0]   mem [WORDS];
        logic [AW-1:0] bus_idx;
        logic [AW-1:0] ld_idx;
        logic          bus_we;
        logic          ld_we;

        assign bus_idx = widx_q[AW-1:0];
        assign ld_idx  = ld_addr[AW-1:0];
        assign bus_we  = bus_wr && (region_q == 2'(g));
        assign ld_we   = ld_en && (ld_region == 2'(g)) &&
                         ({1'b0, ld_addr} < 19'(WORDS));

        // The preload write comes last so it overrides a bus write to the
        // same word on the same edge.
        always_ff @(posedge clk) begin
            if (bus_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_q[b]) mem[bus_idx][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
            if (ld_we) mem[ld_idx] <= ld_data;
        end

        assign rd_word[g] = mem[bus_idx];
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < REGIONS; i++) begin
            if (region_q == 2'(i)) rd_sel = rd_word[i];
        end
    end

    assign bus.wb_ack_o = done_ok;
    assign bus.wb_err_o = (state == DONE) && err_q;
    assign bus.wb_dat_o = done_ok ? rd_sel : '0;

endmodule
